// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants, state encoding and helpers for the mux8_rr_sched round-robin scheduler.
package mux8_rr_sched_pkg;

    localparam int NUM_REQ         = 8;
    localparam int SEL_W           = 3;
    localparam int DEF_BURST_LEN   = 4;
    localparam int DEF_TIMEOUT_CYC = 15;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority picker: first set bit of req scanning ptr, ptr+1, ... wrapping 7->0.
module rr_pick8
    import mux8_rr_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the closest hit to ptr wins last.
    always_comb begin
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8x1 mux with bounded bursts.
// Optional stall watchdog enabled by defining MUX8_SCHED_TIMEOUT_EN.
module mux8_rr_sched
    import mux8_rr_sched_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               out_valid,
    output logic [3:0]         beat_cnt,
    output logic               timeout
);

    if (BURST_LEN < 1 || BURST_LEN > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
        $error("mux8_rr_sched: BURST_LEN or TIMEOUT_CYC out of range");
    end

    state_t             state, state_n;
    logic [SEL_W-1:0]   sel_n, ptr, ptr_n, pick_ptr, pick_idx;
    logic [NUM_REQ-1:0] grant_n;
    logic [3:0]         beat_n;
    logic               pick_any, xfer, last_beat, dropped, wd_fire, release_now;

    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // out_valid never waits on out_ready, and drops the moment req[sel] drops.
    assign out_valid   = (state == S_GRANT) && req[sel];
    assign xfer        = out_valid && out_ready;
    assign last_beat   = xfer && (beat_cnt == 4'(BURST_LEN - 1));
    assign dropped     = (state == S_GRANT) && !req[sel];
    assign release_now = last_beat || dropped || wd_fire;

    // Scanning from sel+1 leaves the current owner last, so it only wins when alone.
    assign pick_ptr = (state == S_GRANT) ? sel + 3'd1 : ptr;

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef MUX8_SCHED_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       timeout_q;
    logic       stalled;

    assign stalled = out_valid && !out_ready;
    assign wd_fire = stalled && (stall_cnt == 8'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
            if (state != S_GRANT || release_now || xfer) stall_cnt <= '0;
            else if (stalled)                            stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        sel_n   = sel;
        grant_n = grant;
        beat_n  = beat_cnt;
        ptr_n   = ptr;
        case (state)
            S_IDLE: begin
                if (en && pick_any) begin
                    state_n = S_GRANT;
                    sel_n   = pick_idx;
                    grant_n = onehot(pick_idx);
                    beat_n  = '0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    ptr_n  = sel + 3'd1;
                    beat_n = '0;
                    if (en && pick_any) begin
                        sel_n   = pick_idx;
                        grant_n = onehot(pick_idx);
                    end else begin
                        state_n = S_IDLE;
                        grant_n = '0;
                    end
                end else if (xfer) begin
                    beat_n = beat_cnt + 4'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
                beat_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
            ptr      <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            grant    <= grant_n;
            beat_cnt <= beat_n;
            ptr      <= ptr_n;
        end
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched: every accepted beat is checked against a queue of expected beats.
module tb_mux8_rr_sched;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic [3:0] beat_cnt;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    // Expected beat = {grant, sel, beat_cnt}.
    logic [14:0] exp_q[$];
    logic [14:0] mon_got;
    logic [14:0] mon_exp;

    mux8_rr_sched #(
        .BURST_LEN   (4),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .beat_cnt  (beat_cnt),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: compare each accepted beat just before the edge that takes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_got = {grant, sel, beat_cnt};
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat", {17'd0, mon_got}, {17'd0, mon_exp});
            end
        end
    end

    task automatic push_burst(input logic [2:0] idx, input int n);
        logic [7:0] g;
        g = 8'd1 << idx;
        for (int b = 0; b < n; b++) exp_q.push_back({g, idx, 4'(b)});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 8'h00;
        en        = 1'b1;
        out_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic drain_check(input string name);
        step(2);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with everything requesting.
        en = 1'b1; req = 8'hFF; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_sel", sel, 0);
        check("rst_grant", grant, 0);
        check("rst_valid", out_valid, 0);
        check("rst_beat", beat_cnt, 0);
        check("rst_timeout", timeout, 0);
        step(2);
        check("rst_hold_grant", grant, 0);
        req = 8'h00; rst_n = 1'b1;
        step(3);
        check("idle_grant", grant, 0);
        check("idle_valid", out_valid, 0);

        // Single requester: one-cycle grant latency, back-to-back regrant.
        do_reset();
        req = 8'h08; out_ready = 1'b1;
        push_burst(3'd3, 4);
        push_burst(3'd3, 4);
        check("s2_pre_grant", grant, 0);
        step(1);
        check("s2_grant", grant, 8'h08);
        check("s2_sel", sel, 3);
        step(8);
        req = 8'h00;
        step(2);
        check("s2_idle", grant, 0);
        drain_check("s2_drain");

        // Round robin across the 7->0 wrap.
        do_reset();
        req = 8'h81; out_ready = 1'b1;
        push_burst(3'd0, 4);
        push_burst(3'd7, 4);
        push_burst(3'd0, 4);
        push_burst(3'd7, 4);
        step(17);
        req = 8'h00;
        step(1);
        drain_check("s3_drain");

        // One beat, stall, then the owner drops its request.
        do_reset();
        req = 8'h60; out_ready = 1'b0;
        step(1);
        check("s4_grant", grant, 8'h20);
        check("s4_sel", sel, 5);
        out_ready = 1'b1;
        push_burst(3'd5, 1);
        step(1);
        out_ready = 1'b0;
        step(3);
        check("s4_stall_beat", beat_cnt, 1);
        check("s4_stall_valid", out_valid, 1);
        check("s4_stall_timeout", timeout, 0);
        req = 8'h40;
        #1;
        check("s4_drop_valid", out_valid, 0);
        step(1);
        check("s4_next_grant", grant, 8'h40);
        check("s4_next_sel", sel, 6);
        check("s4_next_beat", beat_cnt, 0);
        out_ready = 1'b1;
        push_burst(3'd6, 4);
        step(4);
        req = 8'h00;
        drain_check("s4_drain");

        // Enable dropped mid-burst: burst completes, then idles with requests pending.
        do_reset();
        req = 8'h0C; out_ready = 1'b1;
        push_burst(3'd2, 4);
        step(2);
        en = 1'b0;
        step(4);
        check("s5_idle_grant", grant, 0);
        check("s5_idle_valid", out_valid, 0);
        step(1);
        check("s5_idle_hold", grant, 0);
        en = 1'b1;
        push_burst(3'd3, 4);
        step(1);
        check("s5_resume_grant", grant, 8'h08);
        check("s5_resume_sel", sel, 3);
        step(4);
        check("s5_rearb_grant", grant, 8'h04);
        req = 8'h00;
        drain_check("s5_drain");

`ifdef MUX8_SCHED_TIMEOUT_EN
        // Watchdog: 15 stalled cycles force a release to the next requester.
        do_reset();
        req = 8'h06; out_ready = 1'b0;
        step(1);
        check("s6_grant", grant, 8'h02);
        step(14);
        check("s6_pre_timeout", timeout, 0);
        step(1);
        check("s6_timeout", timeout, 1);
        check("s6_moved", grant, 8'h04);
        step(1);
        check("s6_pulse_end", timeout, 0);
        req = 8'h00;
        drain_check("s6_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
